// File: rtl/gskew_update_unit.sv
// gskew_update_unit: speculative GHR plus a FIFO of in-flight predictions, and a three-bank PHT update sequencer.
// Ports: clk, reset (sync, active-high); pred_valid/pred_pc/pred_taken/pred_ready accept predictions;
// res_valid/res_taken/res_ready resolve the oldest one; ghr is the speculative history; mispredict is a 1-cycle pulse;
// pht_addr/pht_rdata/pht_we/pht_wdata drive the counter update; busy is high while an update runs.
// Optional macro GSKEW_UPD_STATS_EN adds stat_branches/stat_mispred saturating counters.
module gskew_update_unit #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pred_valid,
  input  logic [2:0] pred_pc,
  input  logic       pred_taken,
  output logic       pred_ready,
  input  logic       res_valid,
  input  logic       res_taken,
  output logic       res_ready,
  output logic [2:0] ghr,
  output logic       mispredict,
  output logic [2:0] pht_addr,
  input  logic [1:0] pht_rdata,
  output logic       pht_we,
  output logic [1:0] pht_wdata,
  output logic       busy
`ifdef GSKEW_UPD_STATS_EN
  ,
  output logic [7:0] stat_branches,
  output logic [7:0] stat_mispred
`endif
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, UPD_SHARE, UPD_SELECT, UPD_BIMODAL} state_t;
  state_t state, state_nxt;
  logic [6:0] mem [DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic [AW:0] count;
  logic push, pop;
  logic [2:0] u_pc, u_sg;
  logic u_taken;
  logic [2:0] idx_share, idx_select, idx_bimodal;
  assign pred_ready = count != (AW+1)'(DEPTH);
  assign res_ready = state == IDLE && count != '0;
  assign push = pred_valid & pred_ready;
  assign pop = res_valid & res_ready;
  assign busy = state != IDLE;
  // entry layout: {pc, pre-shift ghr, predicted direction}
  always_ff @(posedge clk)
    if (push) mem[wptr] <= {pred_pc, ghr, pred_taken};
  always_ff @(posedge clk) begin
    if (reset) begin
      rptr <= '0;
      wptr <= '0;
      count <= '0;
      ghr <= '0;
      mispredict <= 1'b0;
      u_pc <= '0;
      u_sg <= '0;
      u_taken <= 1'b0;
    end else begin
      mispredict <= pop && mem[rptr][0] != res_taken;
      if (pop) {u_pc, u_sg, u_taken} <= {mem[rptr][6:1], res_taken};
      // a mispredict flushes everything younger, including a push in this cycle, and restores history
      if (mispredict) begin
        rptr <= '0;
        wptr <= '0;
        count <= '0;
        ghr <= {u_sg[1:0], u_taken};
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (push) ghr <= {ghr[1:0], pred_taken};
        if (pop) rptr <= rptr + 1'b1;
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nxt;
  always_comb
    state_nxt = state == IDLE ? (pop ? UPD_SHARE : IDLE) :
                state == UPD_SHARE ? UPD_SELECT :
                state == UPD_SELECT ? UPD_BIMODAL : IDLE;
  assign idx_share = u_pc ^ u_sg;
  assign idx_select = {u_pc[1:0], u_sg[0]};
  assign idx_bimodal = u_pc;
  // later banks skip the write when they alias an earlier bank's counter
  always_comb begin
    pht_addr = state == UPD_SHARE ? idx_share :
               state == UPD_SELECT ? idx_select :
               state == UPD_BIMODAL ? idx_bimodal : 3'd0;
    pht_we = state == UPD_SHARE ||
             (state == UPD_SELECT && idx_select != idx_share) ||
             (state == UPD_BIMODAL && idx_bimodal != idx_share && idx_bimodal != idx_select);
    pht_wdata = state == IDLE ? 2'd0 :
                u_taken ? (pht_rdata == 2'd3 ? 2'd3 : pht_rdata + 2'd1) :
                (pht_rdata == 2'd0 ? 2'd0 : pht_rdata - 2'd1);
  end
`ifdef GSKEW_UPD_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches <= '0;
      stat_mispred <= '0;
    end else begin
      if (state == UPD_SHARE && stat_branches != 8'hff) stat_branches <= stat_branches + 8'd1;
      if (mispredict && stat_mispred != 8'hff) stat_mispred <= stat_mispred + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_gskew_update_unit.sv
// tb_gskew_update_unit: directed self-checking bench for gskew_update_unit.
module tb_gskew_update_unit;
  logic clk, reset;
  logic pred_valid, pred_taken, pred_ready;
  logic [2:0] pred_pc;
  logic res_valid, res_taken, res_ready;
  logic [2:0] ghr, pht_addr;
  logic mispredict, pht_we, busy;
  logic [1:0] pht_rdata, pht_wdata;
`ifdef GSKEW_UPD_STATS_EN
  logic [7:0] stat_branches, stat_mispred;
`endif
  logic [1:0] pht [8];
  logic ld_en;
  logic [2:0] ld_addr;
  logic [1:0] ld_data;
  int checks = 0;
  int failures = 0;
  gskew_update_unit #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_ready(res_ready),
    .ghr(ghr), .mispredict(mispredict),
    .pht_addr(pht_addr), .pht_rdata(pht_rdata), .pht_we(pht_we), .pht_wdata(pht_wdata),
    .busy(busy)
`ifdef GSKEW_UPD_STATS_EN
    , .stat_branches(stat_branches), .stat_mispred(stat_mispred)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign pht_rdata = pht[pht_addr];
  always @(posedge clk)
    if (reset) for (int i = 0; i < 8; i++) pht[i] <= 2'd0;
    else if (pht_we) pht[pht_addr] <= pht_wdata;
    else if (ld_en) pht[ld_addr] <= ld_data;
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [2:0] pc, input logic t);
    pred_valid = 1'b1; pred_pc = pc; pred_taken = t;
    tick();
    pred_valid = 1'b0;
  endtask
  task automatic resolve(input logic t);
    res_valid = 1'b1; res_taken = t;
    tick();
    res_valid = 1'b0;
  endtask
  task automatic load(input logic [2:0] a, input logic [1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    reset = 1'b1; pred_valid = 1'b0; pred_pc = '0; pred_taken = 1'b0;
    res_valid = 1'b0; res_taken = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_ghr", ghr, 0);
    chk("rst_pred_ready", pred_ready, 1);
    chk("rst_res_ready", res_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_we", pht_we, 0);
    chk("rst_mispredict", mispredict, 0);
    // basic correct prediction: pc=3, sg=000 -> indices 3, 6, 3 (bimodal aliases share)
    load(3'd3, 2'd2);
    load(3'd6, 2'd3);
    push(3'd3, 1'b1);
    chk("t1_ghr", ghr, 1);
    chk("t1_res_ready", res_ready, 1);
    resolve(1'b1);
    chk("t1_mispredict", mispredict, 0);
    chk("t1_busy", busy, 1);
    chk("t1_share_addr", pht_addr, 3);
    chk("t1_share_we", pht_we, 1);
    chk("t1_share_wdata", pht_wdata, 3);
    tick();
    chk("t1_pht3", pht[3], 3);
    chk("t1_select_addr", pht_addr, 6);
    chk("t1_select_we", pht_we, 1);
    chk("t1_select_wdata_sat", pht_wdata, 3);
    tick();
    chk("t1_bimodal_addr", pht_addr, 3);
    chk("t1_bimodal_we_dedup", pht_we, 0);
    tick();
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_addr", pht_addr, 0);
    chk("t1_idle_wdata", pht_wdata, 0);
    chk("t1_idle_res_ready", res_ready, 0);
    // fill to DEPTH, overflow attempt ignored
    push(3'd1, 1'b1);
    push(3'd2, 1'b0);
    push(3'd3, 1'b1);
    push(3'd4, 1'b1);
    chk("full_pred_ready", pred_ready, 0);
    chk("full_ghr", ghr, 3);
    push(3'd5, 1'b0);
    chk("full_ghr_after_5th", ghr, 3);
    chk("full_pred_ready_after_5th", pred_ready, 0);
    // head pc=1 sg=001 taken correct
    resolve(1'b1);
    chk("f_e0_mispredict", mispredict, 0);
    chk("f_e0_pred_ready", pred_ready, 1);
    chk("f_e0_share_addr", pht_addr, 0);
    tick(); tick(); tick();
    chk("f_e0_res_ready", res_ready, 1);
    chk("f_e0_ghr", ghr, 3);
    // head pc=2 sg=011 predicted 0, actually 1; push in N+1 is dropped
    resolve(1'b1);
    chk("f_e1_mispredict", mispredict, 1);
    pred_valid = 1'b1; pred_pc = 3'd5; pred_taken = 1'b0;
    tick();
    pred_valid = 1'b0;
    chk("f_e1_pulse_end", mispredict, 0);
    chk("f_e1_ghr_restore", ghr, 7);
    chk("f_e1_pred_ready", pred_ready, 1);
    tick(); tick();
    chk("f_e1_flushed", res_ready, 0);
    chk("f_e1_busy", busy, 0);
    // steer ghr to 101 via a correct and then a mispredicted branch with simultaneous push
    push(3'd7, 1'b0);
    resolve(1'b0);
    tick(); tick(); tick();
    chk("h_ghr", ghr, 6);
    push(3'd0, 1'b0);
    res_valid = 1'b1; res_taken = 1'b1; pred_valid = 1'b1; pred_pc = 3'd6; pred_taken = 1'b1;
    tick();
    res_valid = 1'b0; pred_valid = 1'b0;
    chk("j_ghr_spec", ghr, 1);
    chk("j_mispredict", mispredict, 1);
    tick();
    chk("j_ghr_restore", ghr, 5);
    tick(); tick();
    chk("j_flushed", res_ready, 0);
    // ghr=101: push pc=2 taken=1, second entry, resolve head not taken
    push(3'd2, 1'b1);
    chk("m_ghr_shift", ghr, 3);
    push(3'd5, 1'b0);
    chk("m_ghr_shift2", ghr, 6);
    resolve(1'b0);
    chk("m_mispredict", mispredict, 1);
    tick();
    chk("m_pulse_end", mispredict, 0);
    chk("m_ghr_restore", ghr, 2);
    chk("m_res_ready_busy", res_ready, 0);
    chk("m_pred_ready", pred_ready, 1);
    tick(); tick();
    chk("m_res_ready_empty", res_ready, 0);
    chk("m_busy", busy, 0);
    // res_valid with nothing to resolve does nothing
    res_valid = 1'b1; res_taken = 1'b1;
    tick();
    res_valid = 1'b0;
    chk("nores_busy", busy, 0);
    chk("nores_mispredict", mispredict, 0);
    // all three indices alias to 0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    load(3'd0, 2'd1);
    push(3'd0, 1'b1);
    resolve(1'b1);
    chk("z_share_we", pht_we, 1);
    chk("z_share_wdata", pht_wdata, 2);
    tick();
    chk("z_select_addr", pht_addr, 0);
    chk("z_select_we", pht_we, 0);
    tick();
    chk("z_bimodal_we", pht_we, 0);
    tick();
    chk("z_pht0", pht[0], 2);
    // reset in UPD_SELECT aborts the update
    push(3'd5, 1'b1);
    resolve(1'b1);
    tick();
    chk("r_select_we", pht_we, 1);
    chk("r_select_addr", pht_addr, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("r_we", pht_we, 0);
    chk("r_ghr", ghr, 0);
    chk("r_res_ready", res_ready, 0);
    chk("r_busy", busy, 0);
    tick();
    chk("r_we_later", pht_we, 0);
    chk("r_pred_ready", pred_ready, 1);
`ifdef GSKEW_UPD_STATS_EN
    push(3'd1, 1'b1);
    resolve(1'b1);
    tick(); tick(); tick();
    push(3'd2, 1'b1);
    resolve(1'b0);
    tick(); tick(); tick();
    push(3'd3, 1'b0);
    resolve(1'b0);
    tick(); tick(); tick();
    chk("stat_branches", stat_branches, 3);
    chk("stat_mispred", stat_mispred, 1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
